// File: rtl/if_fetch.sv
// Instruction-fetch stage.
// Each 32-bit instruction is gathered as four little-endian byte reads from a
// byte-wide memory controller. The stage writes the IF/ID registers, signals
// if_stall while no instruction is ready, obeys the stall controller's hold
// bit and redirects on jumps coming back from EX.
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          STALL_W     = 6,
  parameter int          IF_HOLD_BIT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [STALL_W-1:0] i_stall_state,
  input  logic               i_jmp_flag,
  input  logic [31:0]        i_jmp_target,
  output logic               o_mem_req,
  output logic [31:0]        o_mem_addr,
  input  logic               i_mem_ack,
  input  logic [7:0]         i_mem_rdata,
  output logic               o_if_stall,
  output logic [31:0]        o_if_pc,
  output logic [31:0]        o_if_inst,
  output logic               o_if_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_byteCnt;
  logic [31:0] r_ibuf;
  logic [31:0] r_flushAddr;
  logic [31:0] r_ifPc;
  logic [31:0] r_ifInst;
  logic        r_ifValid;

  state_t      w_nextState;
  logic [31:0] w_nextPc;
  logic [1:0]  w_nextCnt;
  logic [31:0] w_nextIbuf;
  logic [31:0] w_nextFlushAddr;
  logic [31:0] w_nextIfPc;
  logic [31:0] w_nextIfInst;
  logic        w_nextIfValid;

  logic        w_hold;
  logic        w_finalAck;
  logic [31:0] w_fetchAddr;
  logic        w_reqPending;
  logic        w_unused;

  // Only the hold bit of the stall code and the word-aligned part of the
  // jump target matter here; the rest is folded away on purpose.
  assign w_unused = ^{i_jmp_target[1:0], i_stall_state};

  assign w_hold       = i_stall_state[IF_HOLD_BIT];
  assign w_fetchAddr  = r_pc + {30'b0, r_byteCnt};
  assign w_reqPending = (r_state == FETCH) || (r_state == FLUSH);
  assign w_finalAck   = (r_state == FETCH) && i_mem_ack && (r_byteCnt == 2'd3);

  // A flush keeps presenting the abandoned address so the outstanding
  // request stays stable until the controller acknowledges it.
  assign o_mem_req  = !i_rst && w_reqPending;
  assign o_mem_addr = (r_state == FLUSH) ? r_flushAddr : w_fetchAddr;
  assign o_if_stall = !i_rst && ((r_state == IDLE) || (r_state == FLUSH) ||
                      ((r_state == FETCH) && !(w_finalAck && !i_jmp_flag)));

  assign o_if_pc    = r_ifPc;
  assign o_if_inst  = r_ifInst;
  assign o_if_valid = r_ifValid;

  // Next-state logic: a jump overrides everything else; otherwise each state
  // collects bytes, hands a finished word to IF/ID or waits for hold/flush.
  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pc;
    w_nextCnt       = r_byteCnt;
    w_nextIbuf      = r_ibuf;
    w_nextFlushAddr = r_flushAddr;
    w_nextIfPc      = r_ifPc;
    w_nextIfInst    = r_ifInst;
    w_nextIfValid   = r_ifValid;

    if (i_jmp_flag) begin
      w_nextPc      = {i_jmp_target[31:2], 2'b00};
      w_nextCnt     = 2'd0;
      w_nextIfValid = 1'b0;
      if (w_reqPending && !i_mem_ack) begin
        w_nextState = FLUSH;
        if (r_state == FETCH) begin
          w_nextFlushAddr = w_fetchAddr;
        end
      end else begin
        w_nextState = FETCH;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_nextState = FETCH;
        end
        FETCH: begin
          if (i_mem_ack) begin
            w_nextIbuf[{r_byteCnt, 3'b000} +: 8] = i_mem_rdata;
            w_nextCnt = r_byteCnt + 2'd1;
          end
          if (w_finalAck) begin
            if (!w_hold) begin
              w_nextIfPc    = r_pc;
              w_nextIfInst  = {i_mem_rdata, r_ibuf[23:0]};
              w_nextIfValid = 1'b1;
              w_nextPc      = r_pc + 32'd4;
            end else begin
              w_nextState = HOLD;
            end
          end else if (!w_hold) begin
            w_nextIfValid = 1'b0;
          end
        end
        HOLD: begin
          if (!w_hold) begin
            w_nextIfPc    = r_pc;
            w_nextIfInst  = r_ibuf;
            w_nextIfValid = 1'b1;
            w_nextPc      = r_pc + 32'd4;
            w_nextState   = FETCH;
          end
        end
        FLUSH: begin
          if (i_mem_ack) begin
            w_nextState = FETCH;
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // State register; reset wins over every other update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_byteCnt   <= 2'd0;
      r_ibuf      <= 32'd0;
      r_flushAddr <= 32'd0;
      r_ifPc      <= 32'd0;
      r_ifInst    <= 32'd0;
      r_ifValid   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPc;
      r_byteCnt   <= w_nextCnt;
      r_ibuf      <= w_nextIbuf;
      r_flushAddr <= w_nextFlushAddr;
      r_ifPc      <= w_nextIfPc;
      r_ifInst    <= w_nextIfInst;
      r_ifValid   <= w_nextIfValid;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by a long randomized run,
// all compared against a transaction-level model of the fetch stage.
module tb_if_fetch;

  localparam int IF_HOLD_BIT = 1;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [5:0]  i_stall_state = '0;
  logic        i_jmp_flag = 1'b0;
  logic [31:0] i_jmp_target = '0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [7:0]  i_mem_rdata = '0;
  logic        o_if_stall;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_inst;
  logic        o_if_valid;

  int checks = 0;
  int errors = 0;

  // Model state: what phase the stage is in, next word start and bytes seen
  bit          mStarting, mHolding, mFlushing;
  logic [31:0] mPc, mFlushAddr;
  int          mCnt;
  logic [31:0] mIfPc, mIfInst;
  bit          mIfValid;

  // Expected and observed values of the most recent cycle
  bit          expReq, expStall;
  logic [31:0] expAddr;
  logic        obsReq, obsStall, obsValid;
  logic [31:0] obsAddr, obsIfPc, obsIfInst;

  if_fetch #(.RESET_PC(32'h0), .STALL_W(6), .IF_HOLD_BIT(IF_HOLD_BIT)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_stall_state(i_stall_state),
    .i_jmp_flag(i_jmp_flag), .i_jmp_target(i_jmp_target),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_if_stall(o_if_stall), .o_if_pc(o_if_pc), .o_if_inst(o_if_inst),
    .o_if_valid(o_if_valid)
  );

  always #5 clk = ~clk;

  // Memory contents: addresses 0..3 hold a NOP (0x00000013), the rest a hash
  function automatic logic [7:0] memByte(input logic [31:0] a);
    if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h6C;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {memByte(a + 32'd3), memByte(a + 32'd2), memByte(a + 32'd1), memByte(a)};
  endfunction

  // One clock cycle: drive inputs, sample combinational outputs, advance the
  // model, then sample the IF/ID registers after the edge.
  task automatic doCycle(input bit rst, input bit ack, input bit hold,
                         input bit jmp, input logic [31:0] target);
    logic [5:0] ss;
    bit fetching, ackEff;
    @(negedge clk);
    fetching = !mStarting && !mHolding && !mFlushing;
    expReq   = !rst && (fetching || mFlushing);
    ackEff   = ack && expReq;
    expAddr  = mFlushing ? mFlushAddr : mPc + 32'(mCnt);
    expStall = !rst && (mStarting || mFlushing ||
               (fetching && !(ackEff && mCnt == 3 && !jmp)));
    ss = 6'($urandom);
    ss[IF_HOLD_BIT] = hold;
    i_rst = rst; i_stall_state = ss; i_jmp_flag = jmp; i_jmp_target = target;
    i_mem_ack = ackEff;
    i_mem_rdata = ackEff ? memByte(o_mem_addr) : 8'($urandom);
    #1;
    obsReq = o_mem_req; obsAddr = o_mem_addr; obsStall = o_if_stall;
    if (rst) begin
      mPc = 32'h0; mCnt = 0; mStarting = 1; mHolding = 0; mFlushing = 0;
      mIfPc = 0; mIfInst = 0; mIfValid = 0;
    end else if (jmp) begin
      if ((fetching || mFlushing) && !ackEff) begin
        if (!mFlushing) mFlushAddr = expAddr;
        mFlushing = 1;
      end else begin
        mFlushing = 0;
      end
      mStarting = 0; mHolding = 0;
      mPc = {target[31:2], 2'b00}; mCnt = 0; mIfValid = 0;
    end else if (mStarting) begin
      mStarting = 0;
    end else if (mHolding) begin
      if (!hold) begin
        mIfPc = mPc; mIfInst = memWord(mPc); mIfValid = 1;
        mPc = mPc + 32'd4; mHolding = 0;
      end
    end else if (mFlushing) begin
      if (ackEff) mFlushing = 0;
    end else if (ackEff && mCnt == 3) begin
      mCnt = 0;
      if (!hold) begin
        mIfPc = mPc; mIfInst = memWord(mPc); mIfValid = 1; mPc = mPc + 32'd4;
      end else begin
        mHolding = 1;
      end
    end else begin
      if (ackEff) mCnt = mCnt + 1;
      if (!hold) mIfValid = 0;
    end
    @(posedge clk);
    #1;
    obsValid = o_if_valid; obsIfPc = o_if_pc; obsIfInst = o_if_inst;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      doCycle(1, 0, 0, 0, 32'h0);
      checks++; if (obsReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", obsReq); end
      checks++; if (obsStall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", obsStall); end
      checks++; if (obsValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", obsValid); end
      checks++; if (obsIfPc !== 32'h0 || obsIfInst !== 32'h0) begin
        errors++; $display("[TB] FAIL reset_ifid got pc=%h inst=%h want 0/0", obsIfPc, obsIfInst); end
    end
  endtask

  task automatic test_first_fetch();
    doCycle(0, 0, 0, 0, 32'h0);
    checks++; if (obsReq !== 1'b0 || obsStall !== 1'b1) begin
      errors++; $display("[TB] FAIL idle got req=%b stall=%b want 0/1", obsReq, obsStall); end
    doCycle(0, 0, 0, 0, 32'h0);
    checks++; if (obsReq !== 1'b1 || obsAddr !== 32'h0) begin
      errors++; $display("[TB] FAIL first_req got req=%b addr=%h want 1/0", obsReq, obsAddr); end
    for (int i = 0; i < 4; i++) begin
      doCycle(0, 1, 0, 0, 32'h0);
      checks++; if (obsAddr !== 32'(i)) begin errors++; $display("[TB] FAIL first_addr got %h want %h", obsAddr, i); end
    end
    checks++; if (obsStall !== 1'b0) begin errors++; $display("[TB] FAIL final_ack_stall got %b want 0", obsStall); end
    checks++; if (obsValid !== 1'b1 || obsIfPc !== 32'h0 || obsIfInst !== 32'h00000013) begin
      errors++; $display("[TB] FAIL first_word got v=%b pc=%h inst=%h want 1/0/00000013", obsValid, obsIfPc, obsIfInst); end
  endtask

  task automatic test_hold();
    doCycle(0, 0, 0, 0, 32'h0);
    checks++; if (obsReq !== 1'b1 || obsAddr !== 32'h4) begin
      errors++; $display("[TB] FAIL next_addr got req=%b addr=%h want 1/4", obsReq, obsAddr); end
    for (int i = 0; i < 3; i++) doCycle(0, 1, 0, 0, 32'h0);
    doCycle(0, 1, 1, 0, 32'h0);
    checks++; if (obsAddr !== 32'h7 || obsStall !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_final got addr=%h stall=%b want 7/0", obsAddr, obsStall); end
    doCycle(0, 0, 1, 0, 32'h0);
    checks++; if (obsReq !== 1'b0 || obsStall !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_state got req=%b stall=%b want 0/0", obsReq, obsStall); end
    checks++; if (obsValid !== 1'b0 || obsIfPc !== 32'h0 || obsIfInst !== 32'h13) begin
      errors++; $display("[TB] FAIL hold_keep got v=%b pc=%h inst=%h want 0/0/13", obsValid, obsIfPc, obsIfInst); end
    doCycle(0, 0, 0, 0, 32'h0);
    checks++; if (obsValid !== 1'b1 || obsIfPc !== 32'h4 || obsIfInst !== memWord(32'h4)) begin
      errors++; $display("[TB] FAIL hold_release got v=%b pc=%h inst=%h want 1/4/%h", obsValid, obsIfPc, obsIfInst, memWord(32'h4)); end
    doCycle(0, 0, 0, 0, 32'h0);
    checks++; if (obsReq !== 1'b1 || obsAddr !== 32'h8) begin
      errors++; $display("[TB] FAIL after_hold_addr got req=%b addr=%h want 1/8", obsReq, obsAddr); end
  endtask

  task automatic test_flush();
    doCycle(0, 1, 0, 0, 32'h0);
    doCycle(0, 1, 0, 0, 32'h0);
    doCycle(0, 0, 0, 1, 32'h100);
    checks++; if (obsStall !== 1'b1 || obsAddr !== 32'hA) begin
      errors++; $display("[TB] FAIL jump_pending got stall=%b addr=%h want 1/a", obsStall, obsAddr); end
    for (int i = 0; i < 2; i++) begin
      doCycle(0, 0, 0, 0, 32'h0);
      checks++; if (obsReq !== 1'b1 || obsAddr !== 32'hA || obsStall !== 1'b1 || obsValid !== 1'b0) begin
        errors++; $display("[TB] FAIL flush_wait got req=%b addr=%h stall=%b v=%b want 1/a/1/0", obsReq, obsAddr, obsStall, obsValid); end
    end
    doCycle(0, 1, 0, 0, 32'h0);
    checks++; if (obsValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_ack_valid got %b want 0", obsValid); end
  endtask

  task automatic test_jump_on_final();
    for (int i = 0; i < 3; i++) begin
      doCycle(0, 1, 0, 0, 32'h0);
      checks++; if (obsAddr !== 32'h100 + 32'(i)) begin
        errors++; $display("[TB] FAIL target_addr got %h want %h", obsAddr, 32'h100 + 32'(i)); end
    end
    doCycle(0, 1, 0, 1, 32'h100);
    checks++; if (obsStall !== 1'b1) begin errors++; $display("[TB] FAIL jump_final_stall got %b want 1", obsStall); end
    checks++; if (obsValid !== 1'b0 || obsIfPc !== 32'h4) begin
      errors++; $display("[TB] FAIL jump_final_discard got v=%b pc=%h want 0/4", obsValid, obsIfPc); end
    doCycle(0, 0, 0, 0, 32'h0);
    checks++; if (obsReq !== 1'b1 || obsAddr !== 32'h100) begin
      errors++; $display("[TB] FAIL refetch got req=%b addr=%h want 1/100", obsReq, obsAddr); end
  endtask

  task automatic test_reset_mid();
    doCycle(0, 1, 0, 0, 32'h0);
    doCycle(0, 1, 0, 0, 32'h0);
    doCycle(1, 0, 0, 0, 32'h0);
    checks++; if (obsReq !== 1'b0 || obsStall !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_comb got req=%b stall=%b want 0/0", obsReq, obsStall); end
    checks++; if (obsValid !== 1'b0 || obsIfPc !== 32'h0 || obsIfInst !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_ifid got v=%b pc=%h inst=%h want 0/0/0", obsValid, obsIfPc, obsIfInst); end
    doCycle(0, 0, 0, 0, 32'h0);
    doCycle(0, 0, 0, 0, 32'h0);
    checks++; if (obsReq !== 1'b1 || obsAddr !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_restart got req=%b addr=%h want 1/0", obsReq, obsAddr); end
  endtask

  task automatic test_align_wrap();
    doCycle(0, 1, 0, 1, 32'h103);
    for (int i = 0; i < 4; i++) begin
      doCycle(0, 1, 0, 0, 32'h0);
      checks++; if (obsAddr !== 32'h100 + 32'(i)) begin
        errors++; $display("[TB] FAIL align_addr got %h want %h", obsAddr, 32'h100 + 32'(i)); end
    end
    checks++; if (obsValid !== 1'b1 || obsIfPc !== 32'h100 || obsIfInst !== memWord(32'h100)) begin
      errors++; $display("[TB] FAIL align_word got v=%b pc=%h inst=%h", obsValid, obsIfPc, obsIfInst); end
    doCycle(0, 1, 0, 1, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) doCycle(0, 1, 0, 0, 32'h0);
    checks++; if (obsValid !== 1'b1 || obsIfPc !== 32'hFFFF_FFFC || obsIfInst !== memWord(32'hFFFF_FFFC)) begin
      errors++; $display("[TB] FAIL wrap_word got v=%b pc=%h inst=%h", obsValid, obsIfPc, obsIfInst); end
    doCycle(0, 0, 0, 0, 32'h0);
    checks++; if (obsAddr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr got %h want 0", obsAddr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      doCycle(($urandom % 200) == 0, ($urandom % 2) == 0, ($urandom % 4) == 0,
              ($urandom % 16) == 0, $urandom);
      checks++; if (obsReq !== expReq || obsStall !== expStall) begin
        errors++; $display("[TB] FAIL rand_comb cyc %0d got req=%b stall=%b want %b/%b", n, obsReq, obsStall, expReq, expStall); end
      if (expReq) begin
        checks++; if (obsAddr !== expAddr) begin
          errors++; $display("[TB] FAIL rand_addr cyc %0d got %h want %h", n, obsAddr, expAddr); end
      end
      checks++; if (obsValid !== mIfValid || obsIfPc !== mIfPc || obsIfInst !== mIfInst) begin
        errors++; $display("[TB] FAIL rand_ifid cyc %0d got v=%b pc=%h inst=%h want %b/%h/%h",
                           n, obsValid, obsIfPc, obsIfInst, mIfValid, mIfPc, mIfInst); end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold();
    test_flush();
    test_jump_on_final();
    test_reset_mid();
    test_align_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
